// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: stall/flush/hold control for a 5-stage pipeline.
// Handles load-use stalls, taken-branch flushes and multi-cycle multiply holds,
// with a sticky watchdog for long load-use stall runs.
// Optional build macro STALL_STATS_EN enables the StallCycles/FlushCount
// statistics counters; without it both ports read constant 0.
module pipeline_stall_controller #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned MAX_STALL  = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        HazardReq,
  input  logic        BranchTaken,
  input  logic        MulStart,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        EX_Hold,
  output logic        StallErr,
  output logic [15:0] StallCycles,
  output logic [15:0] FlushCount
);

  localparam int unsigned CntW  = 4;
  localparam int unsigned StatW = 16;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } stateT;

  stateT           state;
  stateT           nextState;
  logic [CntW-1:0] mulCnt;
  logic [CntW-1:0] mulCntNext;
  logic [CntW-1:0] stallRun;
  logic            hazardStall;

  // Next-state and combinational stall outputs; Reset forces RUN defaults
  always_comb begin
    nextState    = state;
    mulCntNext   = mulCnt;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    EX_Hold      = 1'b0;
    hazardStall  = 1'b0;
    if (!Reset) begin
      case (state)
        RUN: begin
          if (MulStart) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            EX_Hold     = 1'b1;
            mulCntNext  = CntW'(MUL_CYCLES - 1);
            nextState   = MUL_WAIT;
          end else if (HazardReq) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            hazardStall  = 1'b1;
          end else if (BranchTaken) begin
            IF_ID_Flush = 1'b1;
          end
        end
        MUL_WAIT: begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          EX_Hold     = 1'b1;
          mulCntNext  = mulCnt - CntW'(1);
          if (mulCnt <= CntW'(1)) begin
            nextState = RUN;
          end
        end
        default: nextState = RUN;
      endcase
    end
  end

  // State register and multiply down-counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= RUN;
      mulCnt <= '0;
    end else begin
      state  <= nextState;
      mulCnt <= mulCntNext;
    end
  end

  // Load-use watchdog: consecutive stall run length and sticky error flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stallRun <= '0;
      StallErr <= 1'b0;
    end else if (hazardStall) begin
      if (stallRun != '1) begin
        stallRun <= stallRun + CntW'(1);
      end
      if (({1'b0, stallRun} + 5'd1) == 5'(MAX_STALL)) begin
        StallErr <= 1'b1;
      end
    end else begin
      stallRun <= '0;
    end
  end

`ifdef STALL_STATS_EN
  // Saturating statistics: stalled-PC cycles and flush cycles
  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (!PCWrite && (StallCycles != '1)) begin
        StallCycles <= StallCycles + StatW'(1);
      end
      if (IF_ID_Flush && (FlushCount != '1)) begin
        FlushCount <= FlushCount + StatW'(1);
      end
    end
  end
`else
  // Statistics disabled: ports tied off
  assign StallCycles = StatW'(0);
  assign FlushCount  = StatW'(0);
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed-vector bench for pipeline_stall_controller
// (default MUL_CYCLES=4, MAX_STALL=8). Inputs change 1ns after the rising edge;
// outputs are checked on the falling edge or 1ns after the rising edge.
module tb_pipeline_stall_controller;

  logic        Clk;
  logic        Reset;
  logic        HazardReq;
  logic        BranchTaken;
  logic        MulStart;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Bubble;
  logic        EX_Hold;
  logic        StallErr;
  logic [15:0] StallCycles;
  logic [15:0] FlushCount;

  int numChecks = 0;
  int numFails  = 0;

  pipeline_stall_controller #(
    .MUL_CYCLES(4),
    .MAX_STALL (8)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .HazardReq   (HazardReq),
    .BranchTaken (BranchTaken),
    .MulStart    (MulStart),
    .PCWrite     (PCWrite),
    .IF_ID_Write (IF_ID_Write),
    .IF_ID_Flush (IF_ID_Flush),
    .ID_EX_Bubble(ID_EX_Bubble),
    .EX_Hold     (EX_Hold),
    .StallErr    (StallErr),
    .StallCycles (StallCycles),
    .FlushCount  (FlushCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point: counts and reports mismatches
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Statistics expectation; ports read 0 when the feature is not built
  task automatic checkStats(input string tag, input int expStall, input int expFlush);
`ifdef STALL_STATS_EN
    checkVal({tag, ".stallCycles"}, 32'(StallCycles), 32'(expStall));
    checkVal({tag, ".flushCount"},  32'(FlushCount),  32'(expFlush));
`else
    checkVal({tag, ".stallCycles"}, 32'(StallCycles), 32'(expStall * 0));
    checkVal({tag, ".flushCount"},  32'(FlushCount),  32'(expFlush * 0));
`endif
  endtask

  // Drive one cycle of inputs, check all control outputs mid-cycle, advance
  task automatic cyc(input string tag, input logic h, input logic b, input logic m,
                     input logic pc, input logic ifw, input logic fl, input logic bub,
                     input logic hold, input logic err);
    HazardReq   = h;
    BranchTaken = b;
    MulStart    = m;
    @(negedge Clk);
    checkVal({tag, ".PCWrite"},      32'(PCWrite),      32'(pc));
    checkVal({tag, ".IF_ID_Write"},  32'(IF_ID_Write),  32'(ifw));
    checkVal({tag, ".IF_ID_Flush"},  32'(IF_ID_Flush),  32'(fl));
    checkVal({tag, ".ID_EX_Bubble"}, 32'(ID_EX_Bubble), 32'(bub));
    checkVal({tag, ".EX_Hold"},      32'(EX_Hold),      32'(hold));
    checkVal({tag, ".StallErr"},     32'(StallErr),     32'(err));
    tick();
  endtask

  initial begin
    Reset       = 1'b1;
    HazardReq   = 1'b0;
    BranchTaken = 1'b0;
    MulStart    = 1'b0;
    tick();
    tick();

    // Reset forces RUN defaults even with every request asserted
    cyc("rstForce", 1, 1, 1, 1, 1, 0, 0, 0, 0);
    checkStats("rstForce", 0, 0);
    Reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) cyc("idle", 0, 0, 0, 1, 1, 0, 0, 0, 0);
    checkStats("idle", 0, 0);

    // Multiply: EX_Hold for 4 cycles, hazard in cycle 2 ignored
    cyc("mul0", 0, 0, 1, 0, 0, 0, 0, 1, 0);
    cyc("mul1", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mul2", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mul3", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mul4", 0, 0, 0, 1, 1, 0, 0, 0, 0);
    checkStats("mul", 4, 0);

    // All requests together: multiply wins; requests ignored during the wait
    cyc("all0", 1, 1, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc("allWait", 1, 1, 1, 0, 0, 0, 0, 1, 0);
    cyc("allDone", 0, 0, 0, 1, 1, 0, 0, 0, 0);
    checkStats("all", 8, 0);

    // Taken branches flush IF/ID for one cycle each
    for (int i = 0; i < 3; i++) begin
      cyc("br",     0, 1, 0, 1, 1, 1, 0, 0, 0);
      cyc("brIdle", 0, 0, 0, 1, 1, 0, 0, 0, 0);
    end
    checkStats("br", 8, 3);

    // Runs of MAX_STALL-1 hazards separated by a gap never trip the watchdog
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 7; k++) cyc("haz7", 1, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc("haz7Gap", 0, 0, 0, 1, 1, 0, 0, 0, 0);
    end
    checkStats("haz7", 22, 3);

    // 10 consecutive hazards: StallErr visible from the 9th cycle, then sticky
    for (int k = 0; k < 10; k++) cyc("haz10", 1, 0, 0, 0, 0, 0, 1, 0, logic'(k >= 8));
    for (int i = 0; i < 3; i++) cyc("errSticky", 0, 0, 0, 1, 1, 0, 0, 0, 1);
    checkStats("haz10", 32, 3);

    // Reset in the middle of a multiply aborts the hold and clears everything
    cyc("rmul0", 0, 0, 1, 0, 0, 0, 0, 1, 1);
    Reset = 1'b1;
    cyc("rmul1", 0, 0, 0, 1, 1, 0, 0, 0, 1);
    Reset = 1'b0;
    checkStats("rmulRst", 0, 0);
    cyc("rmul2", 0, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc("rmul3", 0, 0, 0, 1, 1, 0, 0, 0, 0);

    // Statistics: 3 branch flushes and 5 hazard stalls
    for (int i = 0; i < 3; i++) begin
      cyc("sBr",     0, 1, 0, 1, 1, 1, 0, 0, 0);
      cyc("sBrIdle", 0, 0, 0, 1, 1, 0, 0, 0, 0);
    end
    for (int k = 0; k < 5; k++) cyc("sHaz", 1, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("sEnd", 0, 0, 0, 1, 1, 0, 0, 0, 0);
    checkStats("stats", 5, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
